// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Y86-64 decode / write-back stage. Decodes register IDs from
//                the D pipeline register, holds the 15-entry register file
//                written from W, resolves valA/valB forwarding and loads the
//                E pipeline register (with bubble support).
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
   parameter int NREG   = 15,
   parameter int RSP_ID = 4
) (
   input  logic        clk,
   input  logic        reset,
   // D pipeline register
   input  logic [3:0]  D_stat,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  D_ifun,
   input  logic [3:0]  D_rA,
   input  logic [3:0]  D_rB,
   input  logic [63:0] D_valC,
   input  logic [63:0] D_valP,
   // pipeline control
   input  logic        E_bubble,
   // forwarding sources
   input  logic [3:0]  e_dstE,
   input  logic [63:0] e_valE,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] M_valE,
   input  logic [63:0] m_valM,
   // W stage: forwarding source and register-file write ports
   input  logic [3:0]  W_dstE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] W_valE,
   input  logic [63:0] W_valM,
   // source IDs for hazard detection
   output logic [3:0]  d_srcA,
   output logic [3:0]  d_srcB,
   // E pipeline register
   output logic [3:0]  E_stat,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_ifun,
   output logic [63:0] E_valC,
   output logic [63:0] E_valA,
   output logic [63:0] E_valB,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB
);

   // Register ID meaning "no register"
   localparam logic [3:0] c_RNONE    = 4'hF;
   localparam logic [3:0] c_RSP      = RSP_ID[3:0];

   // Instruction codes
   localparam logic [3:0] c_I_NOP    = 4'h1;
   localparam logic [3:0] c_I_RRMOVQ = 4'h2;
   localparam logic [3:0] c_I_IRMOVQ = 4'h3;
   localparam logic [3:0] c_I_RMMOVQ = 4'h4;
   localparam logic [3:0] c_I_MRMOVQ = 4'h5;
   localparam logic [3:0] c_I_OPQ    = 4'h6;
   localparam logic [3:0] c_I_JXX    = 4'h7;
   localparam logic [3:0] c_I_CALL   = 4'h8;
   localparam logic [3:0] c_I_RET    = 4'h9;
   localparam logic [3:0] c_I_PUSHQ  = 4'hA;
   localparam logic [3:0] c_I_POPQ   = 4'hB;

   // Status code loaded with a bubble
   localparam logic [3:0] c_STAT_AOK = 4'h1;

   // Decoded register IDs
   logic [3:0]  w_srcA;
   logic [3:0]  w_srcB;
   logic [3:0]  w_dstE;
   logic [3:0]  w_dstM;

   // Register file and its combinational read data
   logic [63:0] r_rf [NREG];
   logic [63:0] w_rf_a;
   logic [63:0] w_rf_b;

   // Forwarded operand values
   logic [63:0] w_valA;
   logic [63:0] w_valB;

   // E pipeline register
   logic [3:0]  r_e_stat;
   logic [3:0]  r_e_icode;
   logic [3:0]  r_e_ifun;
   logic [63:0] r_e_valC;
   logic [63:0] r_e_valA;
   logic [63:0] r_e_valB;
   logic [3:0]  r_e_dstE;
   logic [3:0]  r_e_dstM;
   logic [3:0]  r_e_srcA;
   logic [3:0]  r_e_srcB;

   // Register-ID decode by instruction class; unlisted icodes use no registers
   always_comb begin
      w_srcA = c_RNONE;
      w_srcB = c_RNONE;
      w_dstE = c_RNONE;
      w_dstM = c_RNONE;
      case (D_icode)
         c_I_RRMOVQ: begin
            w_srcA = D_rA;
            w_dstE = D_rB;
         end
         c_I_IRMOVQ: begin
            w_dstE = D_rB;
         end
         c_I_RMMOVQ: begin
            w_srcA = D_rA;
            w_srcB = D_rB;
         end
         c_I_MRMOVQ: begin
            w_srcB = D_rB;
            w_dstM = D_rA;
         end
         c_I_OPQ: begin
            w_srcA = D_rA;
            w_srcB = D_rB;
            w_dstE = D_rB;
         end
         c_I_CALL: begin
            w_srcB = c_RSP;
            w_dstE = c_RSP;
         end
         c_I_RET: begin
            w_srcA = c_RSP;
            w_srcB = c_RSP;
            w_dstE = c_RSP;
         end
         c_I_PUSHQ: begin
            w_srcA = D_rA;
            w_srcB = c_RSP;
            w_dstE = c_RSP;
         end
         c_I_POPQ: begin
            w_srcA = c_RSP;
            w_srcB = c_RSP;
            w_dstE = c_RSP;
            w_dstM = D_rA;
         end
         default: begin
            w_srcA = c_RNONE;
         end
      endcase
   end

   assign d_srcA = w_srcA;
   assign d_srcB = w_srcB;

   // Combinational register-file reads; IDs outside the file (RNONE) read as zero
   always_comb begin
      w_rf_a = '0;
      w_rf_b = '0;
      if (int'(w_srcA) < NREG) begin
         w_rf_a = r_rf[w_srcA];
      end
      if (int'(w_srcB) < NREG) begin
         w_rf_b = r_rf[w_srcB];
      end
   end

   // valA: valP for jumps/calls, else youngest in-flight producer, else register file
   always_comb begin
      w_valA = '0;
      if (D_icode == c_I_JXX || D_icode == c_I_CALL) begin
         w_valA = D_valP;
      end else if (w_srcA != c_RNONE) begin
         if (w_srcA == e_dstE) begin
            w_valA = e_valE;
         end else if (w_srcA == M_dstM) begin
            w_valA = m_valM;
         end else if (w_srcA == M_dstE) begin
            w_valA = M_valE;
         end else if (w_srcA == W_dstM) begin
            w_valA = W_valM;
         end else if (w_srcA == W_dstE) begin
            w_valA = W_valE;
         end else begin
            w_valA = w_rf_a;
         end
      end
   end

   // valB: same producer priority as valA, without the valP case
   always_comb begin
      w_valB = '0;
      if (w_srcB != c_RNONE) begin
         if (w_srcB == e_dstE) begin
            w_valB = e_valE;
         end else if (w_srcB == M_dstM) begin
            w_valB = m_valM;
         end else if (w_srcB == M_dstE) begin
            w_valB = M_valE;
         end else if (w_srcB == W_dstM) begin
            w_valB = W_valM;
         end else if (w_srcB == W_dstE) begin
            w_valB = W_valE;
         end else begin
            w_valB = w_rf_b;
         end
      end
   end

   // Register-file write from W; the dstM write is issued last so it wins a tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NREG; k++) begin
            r_rf[k] <= '0;
         end
      end else begin
         if (W_dstE != c_RNONE && int'(W_dstE) < NREG) begin
            r_rf[W_dstE] <= W_valE;
         end
         if (W_dstM != c_RNONE && int'(W_dstM) < NREG) begin
            r_rf[W_dstM] <= W_valM;
         end
      end
   end

   // E pipeline register: bubble on reset or request, else capture decoded instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_e_stat  <= c_STAT_AOK;
         r_e_icode <= c_I_NOP;
         r_e_ifun  <= 4'h0;
         r_e_valC  <= '0;
         r_e_valA  <= '0;
         r_e_valB  <= '0;
         r_e_dstE  <= c_RNONE;
         r_e_dstM  <= c_RNONE;
         r_e_srcA  <= c_RNONE;
         r_e_srcB  <= c_RNONE;
      end else if (E_bubble) begin
         r_e_stat  <= c_STAT_AOK;
         r_e_icode <= c_I_NOP;
         r_e_ifun  <= 4'h0;
         r_e_valC  <= '0;
         r_e_valA  <= '0;
         r_e_valB  <= '0;
         r_e_dstE  <= c_RNONE;
         r_e_dstM  <= c_RNONE;
         r_e_srcA  <= c_RNONE;
         r_e_srcB  <= c_RNONE;
      end else begin
         r_e_stat  <= D_stat;
         r_e_icode <= D_icode;
         r_e_ifun  <= D_ifun;
         r_e_valC  <= D_valC;
         r_e_valA  <= w_valA;
         r_e_valB  <= w_valB;
         r_e_dstE  <= w_dstE;
         r_e_dstM  <= w_dstM;
         r_e_srcA  <= w_srcA;
         r_e_srcB  <= w_srcB;
      end
   end

   assign E_stat  = r_e_stat;
   assign E_icode = r_e_icode;
   assign E_ifun  = r_e_ifun;
   assign E_valC  = r_e_valC;
   assign E_valA  = r_e_valA;
   assign E_valB  = r_e_valB;
   assign E_dstE  = r_e_dstE;
   assign E_dstM  = r_e_dstM;
   assign E_srcA  = r_e_srcA;
   assign E_srcB  = r_e_srcB;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage. Expected E-register
//                contents are pushed into a scoreboard queue at issue time and
//                popped by a monitor after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

   localparam logic [3:0] F = 4'hF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic        E_bubble;
   logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic [3:0]  d_srcA, d_srcB;
   logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [63:0] E_valC, E_valA, E_valB;

   typedef struct packed {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] valC;
      logic [63:0] valA;
      logic [63:0] valB;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
      logic [3:0]  srcA;
      logic [3:0]  srcB;
   } e_t;

   e_t          exp_q[$];
   logic [63:0] mreg [15];
   int          total = 0;
   int          bad = 0;

   decode_stage #(.NREG(15), .RSP_ID(4)) dut (
      .clk(clk), .reset(reset),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
      .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
      .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return F;
   endfunction

   function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return F;
   endfunction

   function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return F;
   endfunction

   function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return F;
   endfunction

   // Youngest producer first, then the architectural register file
   function automatic logic [63:0] m_fetch(input logic [3:0] src);
      logic [3:0]  ids [5];
      logic [63:0] vs  [5];
      ids = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
      vs  = '{e_valE, m_valM, M_valE, W_valM, W_valE};
      if (src == F) return 64'd0;
      for (int k = 0; k < 5; k++) begin
         if (ids[k] == src) return vs[k];
      end
      return mreg[src];
   endfunction

   function automatic e_t bubble_val();
      e_t b;
      b = '{stat: 4'h1, icode: 4'h1, ifun: 4'h0, valC: 64'd0, valA: 64'd0, valB: 64'd0,
            dstE: F, dstM: F, srcA: F, srcB: F};
      return b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic idle();
      D_stat = 4'h1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = F; D_rB = F;
      D_valC = 64'd0; D_valP = 64'd0; E_bubble = 1'b0;
      e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
      e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
   endtask

   function automatic logic [3:0] rnd_id();
      if ($urandom_range(0, 2) == 0) return F;
      return 4'($urandom_range(0, 14));
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic randomize_inputs();
      D_stat  = 4'($urandom_range(1, 4));
      D_icode = 4'($urandom_range(0, 15));
      D_ifun  = 4'($urandom_range(0, 15));
      D_rA    = 4'($urandom_range(0, 15));
      D_rB    = 4'($urandom_range(0, 15));
      D_valC  = rnd64();
      D_valP  = rnd64();
      E_bubble = ($urandom_range(0, 7) == 0);
      e_dstE = rnd_id(); M_dstE = rnd_id(); M_dstM = rnd_id();
      W_dstE = rnd_id(); W_dstM = rnd_id();
      e_valE = rnd64(); M_valE = rnd64(); m_valM = rnd64();
      W_valE = rnd64(); W_valM = rnd64();
   endtask

   // Called at a falling edge with inputs applied; predicts the E register
   // after the coming rising edge and the register-file update it performs.
   task automatic issue();
      e_t x;
      logic [3:0] sa, sb;
      #1;
      sa = m_srcA(D_icode, D_rA);
      sb = m_srcB(D_icode, D_rB);
      chk("d_srcA", {60'd0, d_srcA}, {60'd0, sa});
      chk("d_srcB", {60'd0, d_srcB}, {60'd0, sb});
      if (E_bubble) begin
         x = bubble_val();
      end else begin
         x.stat  = D_stat;
         x.icode = D_icode;
         x.ifun  = D_ifun;
         x.valC  = D_valC;
         x.valA  = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_fetch(sa);
         x.valB  = m_fetch(sb);
         x.dstE  = m_dstE(D_icode, D_rB);
         x.dstM  = m_dstM(D_icode, D_rA);
         x.srcA  = sa;
         x.srcB  = sb;
      end
      exp_q.push_back(x);
      if (W_dstE != F) mreg[W_dstE] = W_valE;
      if (W_dstM != F) mreg[W_dstM] = W_valM;
      @(negedge clk);
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      e_t got, expv;
      #1;
      if (!reset && exp_q.size() > 0) begin
         expv = exp_q.pop_front();
         got = '{stat: E_stat, icode: E_icode, ifun: E_ifun, valC: E_valC, valA: E_valA,
                 valB: E_valB, dstE: E_dstE, dstM: E_dstM, srcA: E_srcA, srcB: E_srcB};
         total++;
         if (got !== expv) begin
            bad++;
            $display("FAIL e_reg: got st=%h ic=%h fn=%h C=%h A=%h B=%h dE=%h dM=%h sA=%h sB=%h expected st=%h ic=%h fn=%h C=%h A=%h B=%h dE=%h dM=%h sA=%h sB=%h",
                     got.stat, got.icode, got.ifun, got.valC, got.valA, got.valB,
                     got.dstE, got.dstM, got.srcA, got.srcB,
                     expv.stat, expv.icode, expv.ifun, expv.valC, expv.valA, expv.valB,
                     expv.dstE, expv.dstM, expv.srcA, expv.srcB);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      idle();
      for (int k = 0; k < 15; k++) mreg[k] = 64'd0;

      // reset raised between edges takes effect immediately
      #2 reset = 1'b1;
      #1;
      chk("rst_E_icode", {60'd0, E_icode}, 64'd1);
      chk("rst_E_dstE",  {60'd0, E_dstE},  64'hF);
      chk("rst_E_valA",  E_valA,           64'd0);
      chk("rst_E_stat",  {60'd0, E_stat},  64'd1);
      E_bubble = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      E_bubble = 1'b0;

      // registers read zero after reset
      idle(); D_icode = 4'h6; D_rA = 4'd7; D_rB = 4'd9; issue();
      chk("rf_zero_A", E_valA, 64'd0);
      chk("rf_zero_B", E_valB, 64'd0);

      // write then read back through the register file
      idle(); W_dstE = 4'd3; W_valE = 64'h55; issue();
      idle(); D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd3; issue();
      chk("rf_rd_A", E_valA, 64'h55);
      chk("rf_rd_B", E_valB, 64'h55);
      chk("opq_dstE", {60'd0, E_dstE}, 64'd3);

      // forwarding priority
      idle(); D_icode = 4'h2; D_rA = 4'd2; D_rB = 4'd6;
      e_dstE = 4'd2; e_valE = 64'h11; M_dstE = 4'd2; M_valE = 64'h22;
      W_dstE = 4'd2; W_valE = 64'h33;
      issue();
      chk("fwd_e", E_valA, 64'h11);
      e_dstE = F;
      issue();
      chk("fwd_M", E_valA, 64'h22);

      // call and popq
      idle(); D_icode = 4'h8; D_valP = 64'h40; issue();
      chk("call_valA", E_valA, 64'h40);
      chk("call_srcB", {60'd0, E_srcB}, 64'd4);
      chk("call_dstE", {60'd0, E_dstE}, 64'd4);
      idle(); D_icode = 4'hB; D_rA = 4'd0;
      #1 chk("popq_d_srcA", {60'd0, d_srcA}, 64'd4);
      issue();
      chk("popq_dstM", {60'd0, E_dstM}, 64'd0);
      chk("popq_dstE", {60'd0, E_dstE}, 64'd4);

      // dual write to the same register: memory value wins
      idle(); W_dstE = 4'd5; W_dstM = 4'd5; W_valE = 64'd1; W_valM = 64'd2; issue();
      idle(); issue();
      idle(); D_icode = 4'h2; D_rA = 4'd5; D_rB = 4'd1; issue();
      chk("dual_wr", E_valA, 64'd2);

      // bubble then pass-through
      idle(); D_icode = 4'h6; D_rA = 4'd1; D_rB = 4'd2; E_bubble = 1'b1; issue();
      chk("bub_icode", {60'd0, E_icode}, 64'd1);
      chk("bub_dstE",  {60'd0, E_dstE},  64'hF);
      chk("bub_dstM",  {60'd0, E_dstM},  64'hF);
      E_bubble = 1'b0; issue();
      chk("pass_icode", {60'd0, E_icode}, 64'd6);
      chk("pass_dstE",  {60'd0, E_dstE},  64'd2);

      // randomized traffic
      repeat (400) begin
         randomize_inputs();
         issue();
      end

      // reset in mid-run, between edges, with bubble not requested
      idle();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst2_E_icode", {60'd0, E_icode}, 64'd1);
      chk("rst2_E_dstE",  {60'd0, E_dstE},  64'hF);
      chk("rst2_E_valA",  E_valA,           64'd0);
      for (int k = 0; k < 15; k++) mreg[k] = 64'd0;
      @(negedge clk);
      reset = 1'b0;
      idle(); D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd5; issue();
      chk("rst2_rf_A", E_valA, 64'd0);
      chk("rst2_rf_B", E_valB, 64'd0);

      repeat (100) begin
         randomize_inputs();
         issue();
      end

      idle();
      @(posedge clk);
      #2;
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Y86-64 pipeline decode/write-back stage.
- Consumes the D pipeline register outputs produced by the fetch stage: D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP.
- Holds the 15-entry register file, which is written from the W stage, and resolves data forwarding for valA/valB.
- Drives the E pipeline register. Exports d_srcA/d_srcB so the hazard-control unit can detect load/use hazards.

Parameters:
- NREG, 15, number of architectural registers (IDs 0..14); ID 15 (RNONE) means no register.
- RSP_ID, 4, register ID of %rsp.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous active-high reset.
- D_stat  input  4  stage status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- D_icode, D_ifun, D_rA, D_rB  input  4 each  decoded instruction fields.
- D_valC, D_valP  input  64 each  constant and next PC.
- E_bubble  input  1  load a bubble into E on the next edge.
- e_dstE  input  4  execute-stage destination; e_valE  input  64  its value.
- M_dstE, M_dstM  input  4 each; M_valE, m_valM  input  64 each.
- W_dstE, W_dstM  input  4 each; W_valE, W_valM  input  64 each; these are also the register-file write ports.
- d_srcA, d_srcB  output  4 each  combinational source IDs.
- E_stat, E_icode, E_ifun  output  4 each.
- E_valC, E_valA, E_valB  output  64 each.
- E_dstE, E_dstM, E_srcA, E_srcB  output  4 each.

Behaviour:
- Register-ID decode (combinational). icode values: 2 rrmovq/cmov, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
  - srcA: rA for 2, 4, 6, A; RSP_ID for 9, B; otherwise F.
  - srcB: rB for 4, 5, 6; RSP_ID for 8, 9, A, B; otherwise F.
  - dstE: rB for 2, 3, 6; RSP_ID for 8, 9, A, B; otherwise F.
  - dstM: rA for 5, B; otherwise F.
- valA selection, in priority order:
  1. D_valP when icode is 7 or 8.
  2. e_valE if srcA==e_dstE.
  3. m_valM if srcA==M_dstM.
  4. M_valE if srcA==M_dstE.
  5. W_valM if srcA==W_dstM.
  6. W_valE if srcA==W_dstE.
  7. Register-file read.
  - A match is never taken when the ID is F. If srcA is F and no earlier case applies, valA is 0.
- valB selection: same priority chain using srcB, without the valP case.
- Register file:
  - Reads are combinational.
  - On posedge: write W_valE to W_dstE if that ID is not F, and W_valM to W_dstM if that ID is not F.
  - If W_dstE==W_dstM (and not F), W_valM wins.
  - Same-cycle read-after-write is covered by the W forwarding path.
- E register, on posedge:
  - If E_bubble=1: load the bubble value.
  - Otherwise: load the decoded fields, selected valA/valB, D_valC, and D_stat/icode/ifun.
- Bubble value: stat=1, icode=1 (nop), ifun=0, valC/valA/valB=0, dstE/dstM/srcA/srcB=F.
- Reset (asynchronous, takes effect mid-cycle):
  - All registers are cleared to 0.
  - All E outputs take the bubble value.
  - Reset dominates E_bubble.
  - After reset deasserts, the first posedge behaves normally.
- Latency: D inputs appear on the E outputs after exactly one posedge.
- Only D_stat is passed through; invalid icodes (above B) decode all IDs to F.

Test Plan:
- Reset asserted between edges -> E_icode=1, E_dstE=F and E_valA=0 immediately; reading any register returns 0.
- Write W_dstE=3, W_valE=0x55, then decode OPq with rA=3, rB=3 and no forwarding -> E_valA=E_valB=0x55, E_dstE=3.
- Forwarding priority: srcA=2 with e_dstE=2/e_valE=0x11, M_dstE=2/M_valE=0x22 and W_dstE=2/W_valE=0x33 -> E_valA=0x11. Drop e_dstE -> 0x22.
- Decode call with D_valP=0x40 -> E_valA=0x40, srcB=dstE=4. Decode popq rA=0 -> d_srcA=4, E_dstM=0, E_dstE=4.
- Dual write with W_dstE=W_dstM=5, W_valE=1, W_valM=2 -> a later read of register 5 returns 2.
- E_bubble=1 on an OPq -> E_icode=1 and all dst fields F; the next edge with E_bubble=0 passes the instruction through.
